// File: rtl/bcd_to_binary_if.sv
// Interface bundling the BCD input code with the registered conversion results.
//   bcd     : packed two-digit BCD code (tens in [7:4], units in [3:0])
//   binario : registered 4-bit binary equivalent
//   err     : registered flag, high when the sampled code was not 00..15
// master : the BCD source (drives bcd, observes results)
// slave  : the converter (samples bcd, drives results)
interface bcd_to_binary_if;
    logic [7:0] bcd;
    logic [3:0] binario;
    logic       err;

    modport master (
        output bcd,
        input  binario,
        input  err
    );

    modport slave (
        input  bcd,
        output binario,
        output err
    );
endinterface

// File: rtl/bcd_to_binary.sv
// Registered two-digit packed BCD to 4-bit binary converter.
// Accepts codes 00..15 decimal; every other code yields binario=0 and err=1.
// One-cycle latency, one conversion per cycle, no enable.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, clears binario and err
//   bus : bcd_to_binary_if.slave (bcd in; binario, err out)
module bcd_to_binary (
    input  logic              clk,
    input  logic              rst,
    bcd_to_binary_if.slave    bus
);

    logic [3:0] tens;
    logic [3:0] units;
    // Eight bits hold 15*10+15 without wrapping, so the range check is exact
    // even for codes whose tens digit is not legal BCD.
    logic [7:0] value;
    logic       legal;

    logic [3:0] binario_d, binario_q;
    logic       err_d, err_q;

    always_comb begin
        tens      = bus.bcd[7:4];
        units     = bus.bcd[3:0];
        value     = 8'(tens) * 8'd10 + 8'(units);
        legal     = (units <= 4'd9) && (tens <= 4'd1) && (value <= 8'd15);
        binario_d = '0;
        err_d     = 1'b1;
        if (legal) begin
            binario_d = value[3:0];
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            binario_q <= '0;
            err_q     <= 1'b0;
        end else begin
            binario_q <= binario_d;
            err_q     <= err_d;
        end
    end

    assign bus.binario = binario_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bcd_to_binary_if bus ();

    bcd_to_binary dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs on the falling edge, let one rising edge capture them,
    // then compare #1 after that edge.
    task automatic step(input logic [7:0] code, input logic r,
                        input logic [3:0] exp_bin, input logic exp_err,
                        input string tag);
        @(negedge clk);
        bus.bcd = code;
        rst     = r;
        @(posedge clk);
        #1;
        checks++;
        assert (bus.binario === exp_bin) else begin
            errors++;
            $error("FAIL %s bcd=%h: binario=%0d expected %0d", tag, code, bus.binario, exp_bin);
        end
        checks++;
        assert (bus.err === exp_err) else begin
            errors++;
            $error("FAIL %s bcd=%h: err=%0b expected %0b", tag, code, bus.err, exp_err);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.bcd = 8'h00;

        // Reset held two cycles with a legal code on the input.
        step(8'h15, 1'b1, 4'd0, 1'b0, "reset0");
        step(8'h15, 1'b1, 4'd0, 1'b0, "reset1");
        step(8'h15, 1'b0, 4'd15, 1'b0, "post_reset");

        // Single digits 0..9.
        step(8'h00, 1'b0, 4'd0, 1'b0, "digit");
        step(8'h01, 1'b0, 4'd1, 1'b0, "digit");
        step(8'h02, 1'b0, 4'd2, 1'b0, "digit");
        step(8'h03, 1'b0, 4'd3, 1'b0, "digit");
        step(8'h04, 1'b0, 4'd4, 1'b0, "digit");
        step(8'h05, 1'b0, 4'd5, 1'b0, "digit");
        step(8'h06, 1'b0, 4'd6, 1'b0, "digit");
        step(8'h07, 1'b0, 4'd7, 1'b0, "digit");
        step(8'h08, 1'b0, 4'd8, 1'b0, "digit");
        step(8'h09, 1'b0, 4'd9, 1'b0, "digit");

        // Bad units digit.
        step(8'h0A, 1'b0, 4'd0, 1'b1, "bad_units");
        step(8'h0B, 1'b0, 4'd0, 1'b1, "bad_units");
        step(8'h0C, 1'b0, 4'd0, 1'b1, "bad_units");
        step(8'h0D, 1'b0, 4'd0, 1'b1, "bad_units");
        step(8'h0E, 1'b0, 4'd0, 1'b1, "bad_units");
        step(8'h0F, 1'b0, 4'd0, 1'b1, "bad_units");
        step(8'h1C, 1'b0, 4'd0, 1'b1, "bad_units");

        // Two-digit legal range.
        step(8'h10, 1'b0, 4'd10, 1'b0, "two_digit");
        step(8'h11, 1'b0, 4'd11, 1'b0, "two_digit");
        step(8'h12, 1'b0, 4'd12, 1'b0, "two_digit");
        step(8'h13, 1'b0, 4'd13, 1'b0, "two_digit");
        step(8'h14, 1'b0, 4'd14, 1'b0, "two_digit");
        step(8'h15, 1'b0, 4'd15, 1'b0, "two_digit");

        // Legal digits, value out of range.
        step(8'h16, 1'b0, 4'd0, 1'b1, "out_of_range");
        step(8'h17, 1'b0, 4'd0, 1'b1, "out_of_range");
        step(8'h18, 1'b0, 4'd0, 1'b1, "out_of_range");
        step(8'h19, 1'b0, 4'd0, 1'b1, "out_of_range");

        // Bad tens digit.
        step(8'h20, 1'b0, 4'd0, 1'b1, "bad_tens");
        step(8'h99, 1'b0, 4'd0, 1'b1, "bad_tens");
        step(8'hA0, 1'b0, 4'd0, 1'b1, "bad_tens");
        step(8'hFF, 1'b0, 4'd0, 1'b1, "bad_tens");

        // Back-to-back alternation: legal / illegal / legal.
        step(8'h07, 1'b0, 4'd7, 1'b0, "alternate");
        step(8'h1A, 1'b0, 4'd0, 1'b1, "alternate");
        step(8'h13, 1'b0, 4'd13, 1'b0, "alternate");

        // Binary ramp 0x00..0x15: 0x00-0x09 -> 0-9, 0x0A-0x0F -> err,
        // 0x10-0x15 -> 10-15 (raw code minus 6).
        for (int unsigned i = 0; i <= 21; i++) begin
            if (i <= 9)
                step(8'(i), 1'b0, 4'(i), 1'b0, "ramp");
            else if (i <= 15)
                step(8'(i), 1'b0, 4'd0, 1'b1, "ramp");
            else
                step(8'(i), 1'b0, 4'(i - 6), 1'b0, "ramp");
        end

        // Ramp with reset asserted at 0x12, then resumed.
        step(8'h10, 1'b0, 4'd10, 1'b0, "ramp2");
        step(8'h11, 1'b0, 4'd11, 1'b0, "ramp2");
        step(8'h12, 1'b1, 4'd0, 1'b0, "mid_reset");
        step(8'h12, 1'b0, 4'd12, 1'b0, "resume");
        step(8'h13, 1'b0, 4'd13, 1'b0, "resume");
        step(8'h14, 1'b0, 4'd14, 1'b0, "resume");
        step(8'h15, 1'b0, 4'd15, 1'b0, "resume");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
